b06_rr_sched: RTL
=================

Name: b06_rr_sched

Overview:
- Round-robin scheduler that shares one b06-style compare/handshake resource among NREQ requesters.
- Picks a winner, issues a one-cycle start with the winner index on cc_sel, then waits for the resource's eql completion.
- On completion it returns a one-cycle ack to the winner; if no completion arrives within TIMEOUT counted cycles it flags an error.
- Sits between the requesting agents and the shared resource.

Parameters:
- NREQ, 4, number of requesters. Legal range 2..4, because cc_sel is 2 bits.
- TIMEOUT, 15, number of counted WAIT cycles allowed before an error is raised.
- CNT_W, 4, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level. Must be held until ack, or dropped to abort.
- eql  input  1  resource completion indication, sampled in WAIT.
- cont_eql  input  1  resource stall. While 1 in WAIT, the wait counter holds its value.
- grant  output  NREQ  one-hot grant, registered.
- start  output  1  one-cycle pulse launching the resource operation.
- cc_sel  output  2  winner index driven to the resource mux; held while grant is nonzero.
- ack  output  NREQ  one-cycle completion pulse to the winner.
- timeout_err  output  1  one-cycle pulse on timeout.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE; grant, ack, start, timeout_err, busy = 0; cc_sel = 2'b00; cnt = 0.
  - last = NREQ-1, so req[0] has first priority after reset.
- All outputs are registered and change only on a clock edge or on reset.
- Reset asserted mid-operation aborts immediately to the reset values. No ack or error is issued for the aborted transaction.
- Arbitration:
  - Search order is last+1, last+2, … modulo NREQ; the first set req bit wins.
  - last updates to the winner only on leaving DONE or ERR, not on an abort.
- States:
  - IDLE, when req == 0:
    - stay in IDLE.
  - IDLE, when any req bit is set:
    - go to ISSUE;
    - grant = onehot(winner), cc_sel = winner, start = 1, busy = 1.
  - ISSUE (always exactly one cycle):
    - go to WAIT;
    - start = 0, cnt = 0.
  - WAIT, checked at each edge in this priority order:
    1. eql == 1: go to DONE. Set ack[winner] = 1, grant = 0. Completion wins even if req[winner] dropped in the same cycle.
    2. req[winner] == 0: abort to IDLE. grant = 0, busy = 0. No ack, no error, last unchanged.
    3. cnt == TIMEOUT: go to ERR. Set timeout_err = 1, grant = 0.
    4. Otherwise: cnt = cnt + 1 if cont_eql == 0; cnt holds if cont_eql == 1.
  - DONE: ack = 0, last = winner, go to IDLE. busy drops on that edge.
  - ERR: timeout_err = 0, last = winner, go to IDLE. busy drops on that edge.
- Changes to req bits other than the winner's are ignored until the next IDLE.
- Timing:
  - Minimum latency, req seen in IDLE to ack high: 3 clock edges.
  - Re-arbitration occurs no earlier than 1 cycle after ack, because IDLE is always passed through.
  - With cont_eql == 0 throughout, timeout_err pulses on the (TIMEOUT+1)th WAIT edge.
- cnt never wraps. It saturates at TIMEOUT, and the timeout check takes precedence at that value.
- grant is at most one-hot, and ack[i] is only ever asserted for the bit i that was granted.

Test Plan:
- After reset, hold req = 4'b0001; drive eql = 1 on the first WAIT cycle.
  - Expect grant = 0001, cc_sel = 0, one start pulse, then ack = 0001 for exactly one cycle at edge 3.
  - busy returns to 0 one edge later.
- Hold req = 4'b1111 continuously; complete each transaction with eql.
  - Expect grants in the order 0001, 0010, 0100, 1000, 0001, with cc_sel = 0, 1, 2, 3, 0.
- Hold req = 4'b0100; keep eql = 0 and cont_eql = 0.
  - Expect timeout_err to pulse once after 16 WAIT edges, no ack, then a fresh grant = 0100.
- Same as the timeout case, but hold cont_eql = 1 for 10 WAIT cycles.
  - Expect timeout_err delayed by exactly 10 cycles (26 WAIT edges total).
- Abort cases with req = 4'b0010:
  - Drop req to 0 in WAIT: expect return to IDLE, no ack, no timeout_err, and next priority still starting from bit 1 (last unchanged).
  - Drop req in the same cycle that eql = 1: expect ack = 0010.
- Assert reset asynchronously in WAIT (between clock edges).
  - Expect all outputs to go to 0 at once, with no ack or error afterwards.
  - With req = 4'b1001 after reset, expect grant = 0001 (req[0] has priority).

Source files
------------

// File: rtl/b06_rr_sched.sv
// Round-robin scheduler that shares one compare/handshake resource among NREQ requesters.
// Each request gets a start pulse, then either an ack on eql or a timeout_err, unless it aborts first.
module b06_rr_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            eql,
   input  logic            cont_eql,
   output logic [NREQ-1:0] grant,
   output logic            start,
   output logic [1:0]      cc_sel,
   output logic [NREQ-1:0] ack,
   output logic            timeout_err,
   output logic            busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ISSUE = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       last;
   logic [1:0]       win;
   logic [1:0]       idx;
   logic             found;

   // Scan last+1, last+2, ... modulo NREQ; the first requester found wins.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = 2'((int'(last) + k) % NREQ);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // cc_sel doubles as the winner register for the whole transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         ack         <= '0;
         start       <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         cc_sel      <= 2'b00;
         cnt         <= '0;
         last        <= 2'(NREQ-1);
      end else begin
         start       <= 1'b0;
         ack         <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state  <= ISSUE;
                  grant  <= NREQ'(1) << win;
                  cc_sel <= win;
                  start  <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               if (eql) begin
                  state <= DONE;
                  ack   <= NREQ'(1) << cc_sel;
                  grant <= '0;
               end else if (!req[cc_sel]) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state       <= ERR;
                  timeout_err <= 1'b1;
                  grant       <= '0;
               end else if (!cont_eql) begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE, ERR: begin
               state <= IDLE;
               last  <= cc_sel;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
